// File: rtl/fir_ctrl_pkg.sv
// Shared opcodes, state encoding and widths for the FIR sequencer.
// No logic; constants and types only.
// No flow control; referenced by the sequencer and its delay line.
package fir_ctrl_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int CNT_W       = 6;
    localparam int OUT_W_DEF   = 14;
    localparam int FIR_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/valid_delay.sv
// DEPTH-stage 1-bit valid shift register with synchronous clear and empty flag.
// Latency: d appears on q DEPTH cycles later.
// No backpressure; shifts every cycle.
module valid_delay
    import fir_ctrl_pkg::*;
#(
    parameter int DEPTH = FIR_LAT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q,
    output logic empty
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (clr) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q     = pipe[DEPTH-1];
    assign empty = ~|pipe;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Decodes host command bytes into FIR coefficient/sample strobes and captures results.
// Latency: strobe 1 cycle after accept; result valid FIR_LAT+1 cycles after strobe.
// Backpressure: in_ready drops in FLUSH; bytes offered then are dropped and flag err.
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int FIR_LAT  = FIR_LAT_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       fir_x_n,
    output logic             fir_tvalid,
    output logic             fir_set_coeffs,
    input  logic [OUT_W-1:0] fir_y_n,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam int TAP_W = $clog2(NUM_TAPS + 1);

    state_t             state, state_nxt;
    logic [TAP_W-1:0]   tap_cnt, tap_cnt_nxt;
    logic [CNT_W-1:0]   samp_cnt, samp_cnt_nxt;
    logic               clearing, clearing_nxt;
    logic [7:0]         x_nxt;
    logic               tvalid_nxt, coeff_nxt;
    logic               accept, pipe_in, pipe_out, pipe_empty;

    assign in_ready  = (state != ST_FLUSH);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;
    assign pipe_in   = fir_tvalid && !fir_set_coeffs;

    valid_delay #(.DEPTH(FIR_LAT)) u_vdly (
        .clk   (clk),
        .clr   (reset),
        .d     (pipe_in),
        .q     (pipe_out),
        .empty (pipe_empty)
    );

    always_comb begin
        state_nxt    = state;
        tap_cnt_nxt  = tap_cnt;
        samp_cnt_nxt = samp_cnt;
        clearing_nxt = clearing;
        x_nxt        = fir_x_n;
        tvalid_nxt   = 1'b0;
        coeff_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (in_data[7:6])
                        OP_NOP: ;
                        OP_LOAD: begin
                            state_nxt   = ST_LOAD;
                            tap_cnt_nxt = '0;
                        end
                        OP_RUN: begin
                            state_nxt    = ST_RUN;
                            samp_cnt_nxt = in_data[CNT_W-1:0];
                        end
                        OP_CLEAR: begin
                            // First zero write issues immediately, so FLUSH lasts NUM_TAPS cycles.
                            state_nxt    = ST_FLUSH;
                            clearing_nxt = 1'b1;
                            tap_cnt_nxt  = TAP_W'(1);
                            tvalid_nxt   = 1'b1;
                            coeff_nxt    = 1'b1;
                            x_nxt        = 8'h00;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    tvalid_nxt  = 1'b1;
                    coeff_nxt   = 1'b1;
                    x_nxt       = in_data;
                    tap_cnt_nxt = tap_cnt + 1'b1;
                    if (tap_cnt == TAP_W'(NUM_TAPS - 1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    tvalid_nxt = 1'b1;
                    x_nxt      = in_data;
                    if (samp_cnt == '0) begin
                        state_nxt    = ST_FLUSH;
                        clearing_nxt = 1'b0;
                    end else begin
                        samp_cnt_nxt = samp_cnt - 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (clearing) begin
                    if (tap_cnt == TAP_W'(NUM_TAPS)) begin
                        state_nxt    = ST_IDLE;
                        clearing_nxt = 1'b0;
                    end else begin
                        tvalid_nxt  = 1'b1;
                        coeff_nxt   = 1'b1;
                        x_nxt       = 8'h00;
                        tap_cnt_nxt = tap_cnt + 1'b1;
                    end
                end else if (!fir_tvalid && pipe_empty) begin
                    // Drain ends only once the last sample strobe has left the delay line.
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            tap_cnt        <= '0;
            samp_cnt       <= '0;
            clearing       <= 1'b0;
            fir_x_n        <= 8'h00;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
            err            <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
        end else begin
            state          <= state_nxt;
            tap_cnt        <= tap_cnt_nxt;
            samp_cnt       <= samp_cnt_nxt;
            clearing       <= clearing_nxt;
            fir_x_n        <= x_nxt;
            fir_tvalid     <= tvalid_nxt;
            fir_set_coeffs <= coeff_nxt;
            err            <= err | (in_valid && !in_ready);
            out_valid      <= pipe_out;
            if (pipe_out) begin
                out_data <= fir_y_n;
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: transaction-level model compared every cycle,
// plus literal checks on captured results, coefficient writes and error flag.
module tb_fir_seq_ctrl;

    localparam int NUM_TAPS = 4;
    localparam int FIR_LAT  = 2;
    localparam int OUT_W    = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       fir_x_n;
    logic             fir_tvalid;
    logic             fir_set_coeffs;
    logic [OUT_W-1:0] fir_y_n;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             err;
    logic [1:0]       state_dbg;

    fir_seq_ctrl #(.NUM_TAPS(NUM_TAPS), .FIR_LAT(FIR_LAT), .OUT_W(OUT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .fir_x_n        (fir_x_n),
        .fir_tvalid     (fir_tvalid),
        .fir_set_coeffs (fir_set_coeffs),
        .fir_y_n        (fir_y_n),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .busy           (busy),
        .err            (err),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    // Stub FIR: output is the input byte delayed FIR_LAT cycles, zero-extended.
    logic [7:0] stub_d [0:FIR_LAT-1];
    always @(posedge clk) begin
        stub_d[0] <= fir_x_n;
        for (int i = 1; i < FIR_LAT; i++) stub_d[i] <= stub_d[i-1];
    end
    assign fir_y_n = {{(OUT_W-8){1'b0}}, stub_d[FIR_LAT-1]};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endfunction

    // Transaction-level reference: mode per spec encoding, scheduled result queue.
    int               mode, taps_left, samp_left, clr_left, last_due;
    bit               clearing, model_on;
    logic             e_ready, e_busy, e_tv, e_coef, e_ov, e_err;
    logic [7:0]       e_x;
    logic [OUT_W-1:0] e_od;
    int               due_q[$];
    logic [OUT_W-1:0] dat_q[$];

    initial begin
        model_on = 0; mode = 0; e_ready = 1; e_busy = 0;
        e_tv = 0; e_coef = 0; e_ov = 0; e_err = 0; e_x = 0; e_od = 0;
    end

    always @(posedge clk) begin : model
        bit acc;
        if (reset) begin
            model_on = 1; mode = 0; clearing = 0;
            e_tv = 0; e_coef = 0; e_x = 0; e_ov = 0; e_od = 0; e_err = 0;
            due_q.delete(); dat_q.delete();
        end else begin
            acc = in_valid && (mode != 3);
            if (in_valid && mode == 3) e_err = 1;
            e_tv = 0; e_coef = 0; e_ov = 0;
            if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
                e_ov = 1;
                e_od = dat_q.pop_front();
                void'(due_q.pop_front());
            end
            case (mode)
                0: if (acc) begin
                    case (in_data[7:6])
                        2'b01: begin mode = 1; taps_left = NUM_TAPS; end
                        2'b10: begin mode = 2; samp_left = int'(in_data[5:0]) + 1; end
                        2'b11: begin
                            mode = 3; clearing = 1; clr_left = NUM_TAPS - 1;
                            e_tv = 1; e_coef = 1; e_x = 8'h00;
                        end
                        default: ;
                    endcase
                end
                1: if (acc) begin
                    e_tv = 1; e_coef = 1; e_x = in_data;
                    taps_left--;
                    if (taps_left == 0) mode = 0;
                end
                2: if (acc) begin
                    e_tv = 1; e_x = in_data;
                    last_due = cyc + 1 + FIR_LAT + 1;
                    due_q.push_back(last_due);
                    dat_q.push_back({{(OUT_W-8){1'b0}}, in_data});
                    samp_left--;
                    if (samp_left == 0) begin mode = 3; clearing = 0; end
                end
                default: begin
                    if (clearing) begin
                        if (clr_left > 0) begin
                            e_tv = 1; e_coef = 1; e_x = 8'h00; clr_left--;
                        end else begin
                            mode = 0; clearing = 0;
                        end
                    end else if (cyc + 1 > last_due) begin
                        mode = 0;
                    end
                end
            endcase
        end
        e_ready = (mode != 3);
        e_busy  = (mode != 0);
        cyc++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("in_ready",   32'(in_ready),       32'(e_ready));
            check("busy",       32'(busy),           32'(e_busy));
            check("state_dbg",  32'(state_dbg),      32'(mode));
            check("fir_tvalid", 32'(fir_tvalid),     32'(e_tv));
            check("set_coeffs", 32'(fir_set_coeffs), 32'(e_coef));
            check("fir_x_n",    32'(fir_x_n),        32'(e_x));
            check("out_valid",  32'(out_valid),      32'(e_ov));
            check("out_data",   32'(out_data),       32'(e_od));
            check("err",        32'(err),            32'(e_err));
        end
    end

    // Observation log for literal checks.
    logic [OUT_W-1:0] obs_q[$];
    logic [7:0]       coef_log[$];
    int               samp_strobes = 0;
    bit               saw55 = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) obs_q.push_back(out_data);
            if (fir_tvalid && fir_set_coeffs) coef_log.push_back(fir_x_n);
            if (fir_tvalid && !fir_set_coeffs) samp_strobes++;
            if (fir_x_n == 8'h55) saw55 = 1;
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL settle_timeout got=busy exp=idle within 200 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ob, cb, sb;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_state",     32'(state_dbg), 32'd0);
        repeat (2) @(negedge clk);

        // LOAD
        ob = obs_q.size(); cb = coef_log.size();
        send(8'h40); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        settle();
        check("load_nwrites", 32'(coef_log.size() - cb), 32'd4);
        check("load_c0", 32'(coef_log[cb]),   32'h01);
        check("load_c1", 32'(coef_log[cb+1]), 32'h02);
        check("load_c2", 32'(coef_log[cb+2]), 32'h03);
        check("load_c3", 32'(coef_log[cb+3]), 32'h04);
        check("load_no_out", 32'(obs_q.size() - ob), 32'd0);
        check("load_state", 32'(state_dbg), 32'd0);

        // RUN x3
        ob = obs_q.size(); sb = samp_strobes;
        send(8'h82); send(8'h10); send(8'h20); send(8'h30);
        settle();
        check("run_nstrobe", 32'(samp_strobes - sb), 32'd3);
        check("run_nout", 32'(obs_q.size() - ob), 32'd3);
        check("run_o0", 32'(obs_q[ob]),   32'h010);
        check("run_o1", 32'(obs_q[ob+1]), 32'h020);
        check("run_o2", 32'(obs_q[ob+2]), 32'h030);

        // CLEAR with a byte offered during the flush
        cb = coef_log.size();
        send(8'hC0); send(8'h55);
        settle();
        check("clr_nwrites", 32'(coef_log.size() - cb), 32'd4);
        for (int i = 0; i < 4; i++) check("clr_zero", 32'(coef_log[cb+i]), 32'h00);
        check("clr_err", 32'(err), 32'd1);
        check("clr_no55", 32'(saw55), 32'd0);

        // Gapped RUN x2
        ob = obs_q.size(); sb = samp_strobes;
        send(8'h81);
        repeat (5) @(negedge clk);
        send(8'hAA);
        repeat (2) @(negedge clk);
        check("gap_midrun_busy", 32'(busy), 32'd1);
        send(8'hBB);
        settle();
        check("gap_nstrobe", 32'(samp_strobes - sb), 32'd2);
        check("gap_nout", 32'(obs_q.size() - ob), 32'd2);
        check("gap_o0", 32'(obs_q[ob]),   32'h0AA);
        check("gap_o1", 32'(obs_q[ob+1]), 32'h0BB);

        // Reset in the middle of a RUN
        ob = obs_q.size();
        send(8'h83); send(8'h11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_state", 32'(state_dbg), 32'd0);
        check("mrst_ready", 32'(in_ready),  32'd1);
        check("mrst_err",   32'(err),       32'd0);
        repeat (6) @(negedge clk);
        check("mrst_no_out", 32'(obs_q.size() - ob), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
